// File: rtl/id_ex_if.sv
// ID/EX boundary bundle: decoded ID fields, forwarding sources and the
// operands/control handed to the EX stage.
interface id_ex_if #(
    parameter int WORD_LEN    = 32,
    parameter int REG_IDX_LEN = 5,
    parameter int ALUCTL_LEN  = 3
);
    logic                   stall;
    logic                   flush;
    logic                   in_valid;
    logic [WORD_LEN-1:0]    in_rs_val;
    logic [WORD_LEN-1:0]    in_rt_val;
    logic [15:0]            in_imm;
    logic [REG_IDX_LEN-1:0] in_rs_idx;
    logic [REG_IDX_LEN-1:0] in_rt_idx;
    logic [REG_IDX_LEN-1:0] in_rd_idx;
    logic [ALUCTL_LEN-1:0]  in_alucontrol;
    logic                   in_alusrc;
    logic                   in_imm_signed;
    logic                   in_regwrite;
    logic                   in_memread;
    logic                   in_memwrite;
    logic                   in_memtoreg;

    logic                   exmem_regwrite;
    logic [REG_IDX_LEN-1:0] exmem_rd;
    logic [WORD_LEN-1:0]    exmem_result;
    logic                   memwb_regwrite;
    logic [REG_IDX_LEN-1:0] memwb_rd;
    logic [WORD_LEN-1:0]    memwb_result;

    logic [WORD_LEN-1:0]    a;
    logic [WORD_LEN-1:0]    b;
    logic [ALUCTL_LEN-1:0]  alucontrol;
    logic [WORD_LEN-1:0]    store_data;
    logic                   ex_valid;
    logic                   ex_regwrite;
    logic                   ex_memread;
    logic                   ex_memwrite;
    logic                   ex_memtoreg;
    logic [REG_IDX_LEN-1:0] ex_rd;
    logic                   load_use_hazard;

    // Decode/hazard side drives the ID fields and observes the EX outputs.
    modport master (
        output stall, flush, in_valid, in_rs_val, in_rt_val, in_imm,
               in_rs_idx, in_rt_idx, in_rd_idx, in_alucontrol, in_alusrc,
               in_imm_signed, in_regwrite, in_memread, in_memwrite, in_memtoreg,
               exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result,
        input  a, b, alucontrol, store_data, ex_valid, ex_regwrite,
               ex_memread, ex_memwrite, ex_memtoreg, ex_rd, load_use_hazard
    );

    modport slave (
        input  stall, flush, in_valid, in_rs_val, in_rt_val, in_imm,
               in_rs_idx, in_rt_idx, in_rd_idx, in_alucontrol, in_alusrc,
               in_imm_signed, in_regwrite, in_memread, in_memwrite, in_memtoreg,
               exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result,
        output a, b, alucontrol, store_data, ex_valid, ex_regwrite,
               ex_memread, ex_memwrite, ex_memtoreg, ex_rd, load_use_hazard
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register feeding the alu, with operand forwarding and
// load-use hazard detection. Forwarding muxes exist only with ID_EX_FORWARD_EN.
module id_ex_reg #(
    parameter int WORD_LEN    = 32,
    parameter int REG_IDX_LEN = 5,
    parameter int ALUCTL_LEN  = 3
) (
    input  logic    clk,
    input  logic    rst,
    id_ex_if.slave  bus
);

    logic                   valid_q,      valid_d;
    logic                   regwrite_q,   regwrite_d;
    logic                   memread_q,    memread_d;
    logic                   memwrite_q,   memwrite_d;
    logic                   memtoreg_q,   memtoreg_d;
    logic                   alusrc_q,     alusrc_d;
    logic [ALUCTL_LEN-1:0]  alucontrol_q, alucontrol_d;
    logic [REG_IDX_LEN-1:0] rs_idx_q,     rs_idx_d;
    logic [REG_IDX_LEN-1:0] rt_idx_q,     rt_idx_d;
    logic [REG_IDX_LEN-1:0] rd_idx_q,     rd_idx_d;
    logic [WORD_LEN-1:0]    rs_val_q,     rs_val_d;
    logic [WORD_LEN-1:0]    rt_val_q,     rt_val_d;
    logic [WORD_LEN-1:0]    imm_q,        imm_d;

    logic [WORD_LEN-1:0]    imm_ext;

    assign imm_ext = {{(WORD_LEN-16){bus.in_imm_signed & bus.in_imm[15]}}, bus.in_imm};

    always_comb begin
        valid_d      = valid_q;
        regwrite_d   = regwrite_q;
        memread_d    = memread_q;
        memwrite_d   = memwrite_q;
        memtoreg_d   = memtoreg_q;
        alusrc_d     = alusrc_q;
        alucontrol_d = alucontrol_q;
        rs_idx_d     = rs_idx_q;
        rt_idx_d     = rt_idx_q;
        rd_idx_d     = rd_idx_q;
        rs_val_d     = rs_val_q;
        rt_val_d     = rt_val_q;
        imm_d        = imm_q;
        if (bus.flush) begin
            // Bubble: everything cleared so nothing stale can match a hazard.
            valid_d      = 1'b0;
            regwrite_d   = 1'b0;
            memread_d    = 1'b0;
            memwrite_d   = 1'b0;
            memtoreg_d   = 1'b0;
            alusrc_d     = 1'b0;
            alucontrol_d = '0;
            rs_idx_d     = '0;
            rt_idx_d     = '0;
            rd_idx_d     = '0;
            rs_val_d     = '0;
            rt_val_d     = '0;
            imm_d        = '0;
        end else if (!bus.stall) begin
            valid_d      = bus.in_valid;
            regwrite_d   = bus.in_valid & bus.in_regwrite;
            memread_d    = bus.in_valid & bus.in_memread;
            memwrite_d   = bus.in_valid & bus.in_memwrite;
            memtoreg_d   = bus.in_valid & bus.in_memtoreg;
            alusrc_d     = bus.in_alusrc;
            alucontrol_d = bus.in_alucontrol;
            rs_idx_d     = bus.in_rs_idx;
            rt_idx_d     = bus.in_rt_idx;
            rd_idx_d     = bus.in_rd_idx;
            rs_val_d     = bus.in_rs_val;
            rt_val_d     = bus.in_rt_val;
            imm_d        = imm_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            alusrc_q     <= 1'b0;
            alucontrol_q <= '0;
            rs_idx_q     <= '0;
            rt_idx_q     <= '0;
            rd_idx_q     <= '0;
            rs_val_q     <= '0;
            rt_val_q     <= '0;
            imm_q        <= '0;
        end else begin
            valid_q      <= valid_d;
            regwrite_q   <= regwrite_d;
            memread_q    <= memread_d;
            memwrite_q   <= memwrite_d;
            memtoreg_q   <= memtoreg_d;
            alusrc_q     <= alusrc_d;
            alucontrol_q <= alucontrol_d;
            rs_idx_q     <= rs_idx_d;
            rt_idx_q     <= rt_idx_d;
            rd_idx_q     <= rd_idx_d;
            rs_val_q     <= rs_val_d;
            rt_val_q     <= rt_val_d;
            imm_q        <= imm_d;
        end
    end

    // Operand 0 is rs, operand 1 is rt.
    logic [WORD_LEN-1:0] src_val [2];
    logic [WORD_LEN-1:0] opnd    [2];

    assign src_val[0] = rs_val_q;
    assign src_val[1] = rt_val_q;

`ifdef ID_EX_FORWARD_EN
    logic [REG_IDX_LEN-1:0] src_idx [2];
    logic                   ex_hit  [2];
    logic                   wb_hit  [2];

    assign src_idx[0] = rs_idx_q;
    assign src_idx[1] = rt_idx_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign ex_hit[gi] = bus.exmem_regwrite && (src_idx[gi] != '0)
                                && (bus.exmem_rd == src_idx[gi]);
            assign wb_hit[gi] = bus.memwb_regwrite && (src_idx[gi] != '0)
                                && (bus.memwb_rd == src_idx[gi]);
            assign opnd[gi]   = ex_hit[gi] ? bus.exmem_result :
                                wb_hit[gi] ? bus.memwb_result : src_val[gi];
        end
    endgenerate
`else
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_nofwd
            assign opnd[gi] = src_val[gi];
        end
    endgenerate

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{rs_idx_q, rt_idx_q, bus.exmem_result,
                                 bus.memwb_result, bus.memwb_regwrite, bus.memwb_rd};
`endif

    assign bus.a           = opnd[0];
    assign bus.b           = alusrc_q ? imm_q : opnd[1];
    assign bus.store_data  = opnd[1];
    assign bus.alucontrol  = alucontrol_q;
    assign bus.ex_valid    = valid_q;
    assign bus.ex_regwrite = regwrite_q;
    assign bus.ex_memread  = memread_q;
    assign bus.ex_memwrite = memwrite_q;
    assign bus.ex_memtoreg = memtoreg_q;
    assign bus.ex_rd       = rd_idx_q;

    // rt only counts as a read when it feeds the alu or is the store value.
    logic id_rt_used;
    logic ex_rd_dep;
    assign id_rt_used = !bus.in_alusrc || bus.in_memwrite;
    assign ex_rd_dep  = (rd_idx_q != '0) && ((rd_idx_q == bus.in_rs_idx)
                        || ((rd_idx_q == bus.in_rt_idx) && id_rt_used));

`ifdef ID_EX_FORWARD_EN
    assign bus.load_use_hazard = !rst && bus.in_valid && valid_q && memread_q && ex_rd_dep;
`else
    logic mem_rd_dep;
    assign mem_rd_dep = (bus.exmem_rd != '0) && ((bus.exmem_rd == bus.in_rs_idx)
                        || ((bus.exmem_rd == bus.in_rt_idx) && id_rt_used));
    assign bus.load_use_hazard = !rst && bus.in_valid &&
                                 ((valid_q && regwrite_q && ex_rd_dep) ||
                                  (bus.exmem_regwrite && mem_rd_dep));
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg; exercises the forwarding build when
// ID_EX_FORWARD_EN is defined, the stall-only build otherwise.
module tb_id_ex_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    id_ex_if #(.WORD_LEN(32), .REG_IDX_LEN(5), .ALUCTL_LEN(3)) bus ();

    id_ex_reg #(.WORD_LEN(32), .REG_IDX_LEN(5), .ALUCTL_LEN(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [2:0]  ctl;
        logic [4:0]  ctrl;     // {valid, regwrite, memread, memwrite, memtoreg}
        logic [4:0]  rd;
        bit          chk_data;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] sd, input logic [2:0] ctl,
                            input logic [4:0] ctrl, input logic [4:0] rd, input bit chk_data);
        exp_t e;
        e.tag = tag; e.a = a; e.b = b; e.sd = sd; e.ctl = ctl;
        e.ctrl = ctrl; e.rd = rd; e.chk_data = chk_data;
        exp_q.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        if (e.chk_data) begin
            check_val({e.tag, ".a"},  bus.a, e.a);
            check_val({e.tag, ".b"},  bus.b, e.b);
            check_val({e.tag, ".sd"}, bus.store_data, e.sd);
        end
        check_val({e.tag, ".ctl"},  {29'd0, bus.alucontrol}, {29'd0, e.ctl});
        check_val({e.tag, ".ctrl"}, {27'd0, bus.ex_valid, bus.ex_regwrite, bus.ex_memread,
                                     bus.ex_memwrite, bus.ex_memtoreg}, {27'd0, e.ctrl});
        check_val({e.tag, ".rd"},   {27'd0, bus.ex_rd}, {27'd0, e.rd});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [31:0] rsv, input logic [31:0] rtv,
                             input logic [15:0] imm, input logic [2:0] ctl, input logic alusrc,
                             input logic sgn, input logic rw, input logic mr, input logic mw);
        bus.in_valid      = v;
        bus.in_rs_idx     = rs;
        bus.in_rt_idx     = rt;
        bus.in_rd_idx     = rd;
        bus.in_rs_val     = rsv;
        bus.in_rt_val     = rtv;
        bus.in_imm        = imm;
        bus.in_alucontrol = ctl;
        bus.in_alusrc     = alusrc;
        bus.in_imm_signed = sgn;
        bus.in_regwrite   = rw;
        bus.in_memread    = mr;
        bus.in_memwrite   = mw;
        bus.in_memtoreg   = mr;
    endtask

    task automatic clear_fwd();
        bus.exmem_regwrite = 1'b0;
        bus.exmem_rd       = 5'd0;
        bus.exmem_result   = 32'd0;
        bus.memwb_regwrite = 1'b0;
        bus.memwb_rd       = 5'd0;
        bus.memwb_result   = 32'd0;
    endtask

    function automatic logic [31:0] alu_model(input logic [31:0] x, input logic [31:0] y,
                                              input logic [2:0] ctl);
        case (ctl)
            3'b010:  return x + y;
            3'b110:  return x - y;
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b111:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_instr(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_fwd();
        #1;
        push_exp("reset", 32'd0, 32'd0, 32'd0, 3'b000, 5'b00000, 5'd0, 1'b1);
        compare_front();
        check_val("reset.hazard", {31'd0, bus.load_use_hazard}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // sub 15 - 10
        set_instr(1'b1, 5'd1, 5'd2, 5'd3, 32'd15, 32'd10, 16'd0, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp("sub", 32'd15, 32'd10, 32'd10, 3'b110, 5'b11000, 5'd3, 1'b1);
        step();
        check_val("sub.alu", alu_model(bus.a, bus.b, bus.alucontrol), 32'd5);

        set_instr(1'b1, 5'd1, 5'd2, 5'd3, 32'd15, 32'd10, 16'hFFFC, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp("imm_sext", 32'd15, 32'hFFFFFFFC, 32'd10, 3'b010, 5'b11000, 5'd3, 1'b1);
        step();
        check_val("imm_sext.alu", alu_model(bus.a, bus.b, bus.alucontrol), 32'd11);

        set_instr(1'b1, 5'd1, 5'd2, 5'd3, 32'd15, 32'd10, 16'hFFFC, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp("imm_zext", 32'd15, 32'h0000FFFC, 32'd10, 3'b001, 5'b11000, 5'd3, 1'b1);
        step();

        // Stall holds the previous contents despite new inputs.
        bus.stall = 1'b1;
        set_instr(1'b1, 5'd7, 5'd9, 5'd12, 32'd99, 32'd77, 16'h0001, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        push_exp("stall", 32'd15, 32'h0000FFFC, 32'd10, 3'b001, 5'b11000, 5'd3, 1'b1);
        step();

        bus.flush = 1'b1;
        push_exp("flush_stall", 32'd0, 32'd0, 32'd0, 3'b000, 5'b00000, 5'd0, 1'b0);
        step();
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // Invalid ID slot never carries live control.
        set_instr(1'b0, 5'd1, 5'd2, 5'd6, 32'd4, 32'd5, 16'd0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        push_exp("invalid", 32'd4, 32'd5, 32'd5, 3'b010, 5'b00000, 5'd6, 1'b1);
        step();

        // Asynchronous reset mid-cycle.
        set_instr(1'b1, 5'd1, 5'd2, 5'd3, 32'd15, 32'd10, 16'd0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp("add", 32'd15, 32'd10, 32'd10, 3'b010, 5'b11000, 5'd3, 1'b1);
        step();
        #2;
        rst = 1'b1;
        #1;
        push_exp("async_rst", 32'd0, 32'd0, 32'd0, 3'b000, 5'b00000, 5'd0, 1'b1);
        compare_front();
        check_val("async_rst.hazard", {31'd0, bus.load_use_hazard}, 32'd0);
        #1;
        rst = 1'b0;

`ifdef ID_EX_FORWARD_EN
        clear_fwd();
        set_instr(1'b1, 5'd3, 5'd5, 5'd6, 32'd1, 32'd2, 16'd0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp("fwd_base", 32'd1, 32'd2, 32'd2, 3'b010, 5'b11000, 5'd6, 1'b1);
        step();
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'd25;
        bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'd7;
        #1;
        check_val("fwd_exmem_prio", bus.a, 32'd25);
        bus.exmem_regwrite = 1'b0;
        #1;
        check_val("fwd_memwb", bus.a, 32'd7);
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd5;
        #1;
        check_val("fwd_rt_b", bus.b, 32'd25);
        check_val("fwd_rt_sd", bus.store_data, 32'd25);

        clear_fwd();
        set_instr(1'b1, 5'd0, 5'd5, 5'd6, 32'd1, 32'd2, 16'd0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp("fwd_r0_base", 32'd1, 32'd2, 32'd2, 3'b010, 5'b11000, 5'd6, 1'b1);
        step();
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'd25;
        bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'd7;
        #1;
        check_val("fwd_r0", bus.a, 32'd1);
        clear_fwd();

        // lw to r8 in EX
        set_instr(1'b1, 5'd1, 5'd2, 5'd8, 32'd0, 32'd0, 16'd4, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        push_exp("lw_r8", 32'd0, 32'd4, 32'd0, 3'b010, 5'b11101, 5'd8, 1'b1);
        step();
        set_instr(1'b1, 5'd8, 5'd2, 5'd9, 32'd0, 32'd0, 16'd0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check_val("hz_rs", {31'd0, bus.load_use_hazard}, 32'd1);
        set_instr(1'b1, 5'd1, 5'd8, 5'd9, 32'd0, 32'd0, 16'd0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check_val("hz_rt_imm", {31'd0, bus.load_use_hazard}, 32'd0);
        set_instr(1'b1, 5'd1, 5'd8, 5'd9, 32'd0, 32'd0, 16'd0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check_val("hz_rt_reg", {31'd0, bus.load_use_hazard}, 32'd1);

        set_instr(1'b1, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 16'd4, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        push_exp("lw_r0", 32'd0, 32'd4, 32'd0, 3'b010, 5'b11101, 5'd0, 1'b1);
        step();
        set_instr(1'b1, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 16'd0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check_val("hz_rd0", {31'd0, bus.load_use_hazard}, 32'd0);
`else
        // addi r4 in EX whose rs (r9) matches a live EX/MEM write.
        clear_fwd();
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd9; bus.exmem_result = 32'd123;
        set_instr(1'b1, 5'd9, 5'd0, 5'd4, 32'd50, 32'd0, 16'd3, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        push_exp("addi_r4", 32'd50, 32'd3, 32'd0, 3'b010, 5'b11000, 5'd4, 1'b1);
        step();
        check_val("nofwd_a_latched", bus.a, 32'd50);
        set_instr(1'b1, 5'd4, 5'd0, 5'd5, 32'd0, 32'd0, 16'd0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check_val("hz_ex_rs", {31'd0, bus.load_use_hazard}, 32'd1);
        set_instr(1'b1, 5'd9, 5'd0, 5'd5, 32'd0, 32'd0, 16'd0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check_val("hz_exmem_rs", {31'd0, bus.load_use_hazard}, 32'd1);
        set_instr(1'b1, 5'd6, 5'd4, 5'd5, 32'd0, 32'd0, 16'd0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check_val("hz_rt_imm", {31'd0, bus.load_use_hazard}, 32'd0);
        bus.in_alusrc = 1'b0;
        #1;
        check_val("hz_rt_reg", {31'd0, bus.load_use_hazard}, 32'd1);

        clear_fwd();
        bus.exmem_regwrite = 1'b1;
        set_instr(1'b1, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 16'd0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp("addi_r0", 32'd0, 32'd0, 32'd0, 3'b010, 5'b11000, 5'd0, 1'b1);
        step();
        set_instr(1'b1, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 16'd0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check_val("hz_rd0", {31'd0, bus.load_use_hazard}, 32'd0);
        clear_fwd();
`endif

        if (exp_q.size() != 0)
            check_val("scoreboard_left", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register sitting directly upstream of the alu: latches decoded operands and control at the ID→EX boundary.
- Drives the alu a, b and alucontrol inputs.
- Resolves operand forwarding from EX/MEM and MEM/WB, selects the extended immediate, and flags load-use hazards back to the hazard/stall logic.

Parameters:
- WORD_LEN, 32, datapath width; matches the alu operand width.
- REG_IDX_LEN, 5, register index width.
- ALUCTL_LEN, 3, alucontrol width. Codes: 010 add, 110 sub, 000 and, 001 or, 111 slt.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  1  hold the current EX contents.
- flush  in  1  load a bubble.
- in_valid  in  1  ID instruction valid.
- in_rs_val, in_rt_val  in  WORD_LEN  register-file read data.
- in_imm  in  16  raw immediate.
- in_rs_idx, in_rt_idx, in_rd_idx  in  REG_IDX_LEN  source and destination register indices.
- in_alucontrol  in  ALUCTL_LEN  decoded ALU operation.
- in_alusrc  in  1  1 = b from immediate.
- in_imm_signed  in  1  1 = sign-extend, 0 = zero-extend.
- in_regwrite, in_memread, in_memwrite, in_memtoreg  in  1  each  control bits.
- exmem_regwrite  in  1, exmem_rd  in  REG_IDX_LEN, exmem_result  in  WORD_LEN  EX/MEM forwarding source.
- memwb_regwrite  in  1, memwb_rd  in  REG_IDX_LEN, memwb_result  in  WORD_LEN  MEM/WB forwarding source.
- a, b  out  WORD_LEN  alu operands.
- alucontrol  out  ALUCTL_LEN  alu operation.
- store_data  out  WORD_LEN  forwarded rt value for stores.
- ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1  each  registered control.
- ex_rd  out  REG_IDX_LEN  registered destination index.
- load_use_hazard  out  1  ID must stall one cycle.

Behaviour:
- Reset: on rst high, all registered state clears to 0 immediately, regardless of clk. This gives a=b=store_data=0, alucontrol=000, ex_valid=0, all ex_* control=0, load_use_hazard=0. Reset asserted mid-stall or mid-flush wins.
- Update on rising clk, priority rst > flush > stall > load:
  - flush=1: load a bubble. ex_valid=0, all control bits 0, alucontrol=000, indices 0. Applies even when stall=1.
  - stall=1, flush=0: hold every register unchanged.
  - otherwise: latch all in_* fields.
  - in_valid=0: control bits are latched as 0, never forwarded as live.
- Immediate extension (registered): 16-bit in_imm is sign-extended when in_imm_signed=1, otherwise zero-extended to WORD_LEN.
- Forwarding (combinational from registered state, zero added latency), applied separately for rs and rt:
  - Source register 0 is never forwarded.
  - If exmem_regwrite and exmem_rd == idx, use exmem_result.
  - Else if memwb_regwrite and memwb_rd == idx, use memwb_result.
  - Else use the latched register value.
  - EX/MEM has priority when both match.
- Output selection:
  - a = forwarded rs.
  - b = latched extended immediate if alusrc=1, else forwarded rt.
  - store_data = forwarded rt always.
  - alucontrol = latched value, passed through unmodified.
- load_use_hazard (combinational), asserted when all of the following hold:
  - in_valid and ex_valid and ex_memread;
  - ex_rd != 0;
  - ex_rd == in_rs_idx, or ex_rd == in_rt_idx with (in_alusrc=0 or in_memwrite=1).
- Bubble outputs: ex_valid=0 with a/b still computed; downstream ignores them.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding muxes are present as described above.
- Undefined: forwarding logic is removed. a, b and store_data come from latched values only. load_use_hazard widens to any RAW dependence on a nonzero destination:
  - ID source matches ex_rd with ex_valid and ex_regwrite; or
  - ID source matches exmem_rd with exmem_regwrite.
- The exmem/memwb result inputs remain as ports but are unused.

Test Plan:
- Reset mid-operation: load rs=15, rt=10, alucontrol=010, then assert rst between edges → all outputs 0 at once, before the next edge.
- Plain load, then alu check:
  - rs=15, rt=10, alusrc=0, alucontrol=110 → after one edge a=15, b=10, alu result=5, ex_valid=1.
  - in_imm=16'hFFFC with imm_signed=1, alusrc=1 → b=32'hFFFFFFFC.
  - Same immediate with imm_signed=0 → b=32'h0000FFFC.
- Forwarding priority:
  - Latched rs_idx=3, rs_val=1; exmem_rd=3, exmem_result=25; memwb_rd=3, memwb_result=7 → a=25.
  - Drop exmem_regwrite → a=7.
  - Set rs_idx=0 with both sources matching 0 → a=1.
- Stall and flush:
  - stall=1 across an edge with new inputs → outputs unchanged.
  - flush=1 together with stall=1 → ex_valid=0, ex_regwrite=0, alucontrol=000 after the edge.
- Load-use hazard:
  - EX holds a valid lw to rd=8; ID has rs=8 → load_use_hazard=1.
  - ID has rt=8 with alusrc=1, memwrite=0 → 0.
  - rd=0 → 0.
- Build without ID_EX_FORWARD_EN: EX addi to rd=4, ID reads rs=4 → load_use_hazard=1, and a equals the latched value, not exmem_result.
